// File: rtl/fetch_controller_pkg.sv
// Shared fetch-stage definitions: the state encoding and the reset PC.
// The PC block uses START_ADDRESS as its reset value.
package fetch_controller_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_t;

  localparam logic [31:0] START_ADDRESS = 32'h0100_0000;

endpackage

// File: rtl/fetch_controller.sv
// Non-pipelined fetch sequencer: one request per instruction, one-entry decode buffer,
// redirects become immediate PC loads and squash whatever response is still in flight.
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_write_enable,
  output logic              pc_immediate,
  output logic [ADDR_W-1:0] pc_immediate_address,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [DATA_W-1:0] imem_resp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              stall,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [31:0]       fetch_count
);

  fetch_state_t state, state_next;
  logic         capture;
  logic         buf_clear;
  logic         deliver;

  always_ff @(posedge clk) begin
    if (rst) state <= S_REQ;
    else     state <= state_next;
  end

  always_comb begin
    state_next           = state;
    pc_write_enable      = 1'b0;
    pc_immediate         = 1'b0;
    pc_immediate_address = '0;
    imem_req_valid       = 1'b0;
    imem_req_addr        = '0;
    capture              = 1'b0;
    buf_clear            = 1'b0;
    deliver              = 1'b0;

    // A redirect loads the PC in every state and pre-empts the advance below.
    if (redirect_valid) begin
      pc_write_enable      = 1'b1;
      pc_immediate         = 1'b1;
      pc_immediate_address = redirect_addr;
    end

    case (state)
      S_REQ: begin
        imem_req_valid = !redirect_valid;
        imem_req_addr  = pc_in;
        if (!redirect_valid && imem_req_ready) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          if (redirect_valid) begin
            state_next = S_REQ;
          end else begin
            capture         = 1'b1;
            pc_write_enable = 1'b1;
            state_next      = S_HOLD;
          end
        end else if (redirect_valid) begin
          state_next = S_DRAIN;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          buf_clear  = 1'b1;
          state_next = S_REQ;
        end else if (inst_ready && !stall) begin
          buf_clear  = 1'b1;
          deliver    = 1'b1;
          state_next = S_REQ;
        end
      end
      S_DRAIN: begin
        // The stale response must be swallowed before a new request may issue.
        if (imem_resp_valid) state_next = S_REQ;
      end
      default: state_next = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_valid  <= 1'b0;
      inst_data   <= '0;
      inst_pc     <= '0;
      fetch_count <= '0;
    end else begin
      if (capture) begin
        inst_valid <= 1'b1;
        inst_data  <= imem_resp_data;
        inst_pc    <= pc_in;
      end else if (buf_clear) begin
        inst_valid <= 1'b0;
      end
      if (deliver) fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Vector table for cycle-exact corner cases, then a randomized stream checked
// against a scoreboard fed by a bench-side PC and memory model.
module tb_fetch_controller;

  localparam logic [31:0] START = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_write_enable, pc_immediate;
  logic [31:0] pc_immediate_address;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        stall, inst_valid, inst_ready;
  logic [31:0] inst_data, inst_pc, fetch_count;

  always #5 clk = ~clk;

  fetch_controller #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in),
    .pc_write_enable(pc_write_enable), .pc_immediate(pc_immediate),
    .pc_immediate_address(pc_immediate_address),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .stall(stall), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc), .fetch_count(fetch_count)
  );

  typedef struct {
    logic [31:0] pc;
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        redir;
    logic [31:0] raddr;
    logic        stl;
    logic        irdy;
    logic        e_we;
    logic        e_imm;
    logic [31:0] e_iaddr;
    logic        e_rqv;
    logic [31:0] e_rqa;
    logic        e_iv;
    logic [31:0] e_idat;
    logic [31:0] e_ipc;
    logic [31:0] e_cnt;
  } vec_t;

  localparam int NV = 20;
  vec_t tv[NV];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] dat;
  } exp_t;
  exp_t sb[$];

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs(input logic [31:0] pc);
    pc_in          = pc;
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data = '0;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    stall          = 1'b0;
    inst_ready     = 1'b0;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0013;
  endfunction

  initial begin
    logic [31:0] pc_model;
    logic        pend;
    logic [31:0] pend_addr;
    int          dly;
    int          nxfer;
    int          ncapt;
    bit          draining;
    exp_t        e;

    //           pc            rdy rv rd            rd  raddr         st ir  we im iaddr         rqv rqa           iv idat          ipc           cnt
    tv[0]  = '{32'h0100_0000, 1, 0, 32'h0,        0, 32'h0,        0, 0,  0, 0, 32'h0,        1, 32'h0100_0000, 0, 32'h0,        32'h0,        32'd0};
    tv[1]  = '{32'h0100_0000, 0, 1, 32'h13,       0, 32'h0,        0, 0,  1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        32'd0};
    tv[2]  = '{32'h0100_0004, 0, 0, 32'h0,        0, 32'h0,        0, 0,  0, 0, 32'h0,        0, 32'h0,        1, 32'h13,       32'h0100_0000, 32'd0};
    tv[3]  = '{32'h0100_0004, 0, 0, 32'h0,        0, 32'h0,        1, 1,  0, 0, 32'h0,        0, 32'h0,        1, 32'h13,       32'h0100_0000, 32'd0};
    tv[4]  = '{32'h0100_0004, 0, 0, 32'h0,        0, 32'h0,        0, 1,  0, 0, 32'h0,        0, 32'h0,        1, 32'h13,       32'h0100_0000, 32'd0};
    tv[5]  = '{32'h0100_0004, 0, 0, 32'h0,        0, 32'h0,        0, 0,  0, 0, 32'h0,        1, 32'h0100_0004, 0, 32'h13,       32'h0100_0000, 32'd1};
    tv[6]  = '{32'h0100_0004, 1, 0, 32'h0,        0, 32'h0,        0, 0,  0, 0, 32'h0,        1, 32'h0100_0004, 0, 32'h13,       32'h0100_0000, 32'd1};
    tv[7]  = '{32'h0100_0004, 0, 0, 32'h0,        1, 32'h0100_0100, 0, 0,  1, 1, 32'h0100_0100, 0, 32'h0,        0, 32'h13,       32'h0100_0000, 32'd1};
    tv[8]  = '{32'h0100_0100, 0, 1, 32'hDEAD,     0, 32'h0,        0, 0,  0, 0, 32'h0,        0, 32'h0,        0, 32'h13,       32'h0100_0000, 32'd1};
    tv[9]  = '{32'h0100_0100, 1, 0, 32'h0,        0, 32'h0,        0, 0,  0, 0, 32'h0,        1, 32'h0100_0100, 0, 32'h13,       32'h0100_0000, 32'd1};
    tv[10] = '{32'h0100_0100, 0, 1, 32'h33,       1, 32'h0100_0200, 0, 0,  1, 1, 32'h0100_0200, 0, 32'h0,        0, 32'h13,       32'h0100_0000, 32'd1};
    tv[11] = '{32'h0100_0200, 1, 0, 32'h0,        0, 32'h0,        0, 0,  0, 0, 32'h0,        1, 32'h0100_0200, 0, 32'h13,       32'h0100_0000, 32'd1};
    tv[12] = '{32'h0100_0200, 0, 1, 32'h44,       0, 32'h0,        0, 0,  1, 0, 32'h0,        0, 32'h0,        0, 32'h13,       32'h0100_0000, 32'd1};
    tv[13] = '{32'h0100_0204, 0, 0, 32'h0,        1, 32'h0100_0300, 0, 1,  1, 1, 32'h0100_0300, 0, 32'h0,        1, 32'h44,       32'h0100_0200, 32'd1};
    tv[14] = '{32'h0100_0300, 1, 0, 32'h0,        1, 32'h0100_0400, 0, 0,  1, 1, 32'h0100_0400, 0, 32'h0100_0300, 0, 32'h44,       32'h0100_0200, 32'd1};
    tv[15] = '{32'h0100_0400, 1, 0, 32'h0,        0, 32'h0,        0, 0,  0, 0, 32'h0,        1, 32'h0100_0400, 0, 32'h44,       32'h0100_0200, 32'd1};
    tv[16] = '{32'h0100_0400, 0, 0, 32'h0,        1, 32'h0100_0500, 0, 0,  1, 1, 32'h0100_0500, 0, 32'h0,        0, 32'h44,       32'h0100_0200, 32'd1};
    tv[17] = '{32'h0100_0500, 0, 0, 32'h0,        1, 32'h0100_0600, 0, 0,  1, 1, 32'h0100_0600, 0, 32'h0,        0, 32'h44,       32'h0100_0200, 32'd1};
    tv[18] = '{32'h0100_0600, 0, 1, 32'hBEEF,     1, 32'h0100_0700, 0, 0,  1, 1, 32'h0100_0700, 0, 32'h0,        0, 32'h44,       32'h0100_0200, 32'd1};
    tv[19] = '{32'h0100_0700, 0, 0, 32'h0,        0, 32'h0,        0, 0,  0, 0, 32'h0,        1, 32'h0100_0700, 0, 32'h44,       32'h0100_0200, 32'd1};

    rst = 1'b1;
    idle_inputs(START);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset.inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("reset.inst_data", inst_data, 32'd0);
    chk("reset.inst_pc", inst_pc, 32'd0);
    chk("reset.fetch_count", fetch_count, 32'd0);
    chk("reset.req_valid", {31'b0, imem_req_valid}, 32'd1);

    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      pc_in           = tv[i].pc;
      imem_req_ready  = tv[i].rdy;
      imem_resp_valid = tv[i].rv;
      imem_resp_data  = tv[i].rd;
      redirect_valid  = tv[i].redir;
      redirect_addr   = tv[i].raddr;
      stall           = tv[i].stl;
      inst_ready      = tv[i].irdy;
      @(negedge clk);
      chk($sformatf("v%0d.pc_we", i), {31'b0, pc_write_enable}, {31'b0, tv[i].e_we});
      chk($sformatf("v%0d.pc_imm", i), {31'b0, pc_immediate}, {31'b0, tv[i].e_imm});
      chk($sformatf("v%0d.pc_imm_addr", i), pc_immediate_address, tv[i].e_iaddr);
      chk($sformatf("v%0d.req_valid", i), {31'b0, imem_req_valid}, {31'b0, tv[i].e_rqv});
      chk($sformatf("v%0d.req_addr", i), imem_req_addr, tv[i].e_rqa);
      chk($sformatf("v%0d.inst_valid", i), {31'b0, inst_valid}, {31'b0, tv[i].e_iv});
      chk($sformatf("v%0d.inst_data", i), inst_data, tv[i].e_idat);
      chk($sformatf("v%0d.inst_pc", i), inst_pc, tv[i].e_ipc);
      chk($sformatf("v%0d.fetch_count", i), fetch_count, tv[i].e_cnt);
    end

    // Memory withholds ready for 4 cycles, then accepts; reset lands in WAIT.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      idle_inputs(32'h0100_0700);
      @(negedge clk);
      chk($sformatf("delay%0d.req_valid", i), {31'b0, imem_req_valid}, 32'd1);
      chk($sformatf("delay%0d.req_addr", i), imem_req_addr, 32'h0100_0700);
      chk($sformatf("delay%0d.pc_we", i), {31'b0, pc_write_enable}, 32'd0);
    end
    @(posedge clk); #1;
    imem_req_ready = 1'b1;
    @(posedge clk); #1;
    idle_inputs(32'h0100_0700);
    rst = 1'b1;
    @(negedge clk);
    chk("wait.req_valid", {31'b0, imem_req_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs(START);
    @(negedge clk);
    chk("rst_mid.req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("rst_mid.req_addr", imem_req_addr, START);
    chk("rst_mid.inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_mid.inst_data", inst_data, 32'd0);
    chk("rst_mid.inst_pc", inst_pc, 32'd0);
    chk("rst_mid.fetch_count", fetch_count, 32'd0);

    // Randomized stream; responses are scored in order of arrival.
    pc_model = START;
    pend = 1'b0;
    pend_addr = '0;
    dly = 0;
    nxfer = 0;
    ncapt = 0;
    for (int c = 0; c < 460; c++) begin
      draining = (c >= 400);
      @(posedge clk); #1;
      pc_in           = pc_model;
      redirect_valid  = 1'b0;
      redirect_addr   = '0;
      imem_req_ready  = draining ? 1'b0 : 1'($urandom_range(0, 1));
      imem_resp_valid = pend && (dly == 0);
      imem_resp_data  = (pend && dly == 0) ? mem_word(pend_addr) : 32'h0;
      stall           = draining ? 1'b0 : ($urandom_range(0, 3) == 0);
      inst_ready      = draining ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (imem_req_valid) chk("stream.req_addr", imem_req_addr, pc_model);
      if (inst_valid && inst_ready && !stall) begin
        if (sb.size() == 0) begin
          chk("stream.unexpected_inst", inst_pc, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("stream.inst_pc", inst_pc, e.pc);
          chk("stream.inst_data", inst_data, e.dat);
        end
        nxfer++;
      end
      if (pc_write_enable) begin
        chk("stream.pc_imm", {31'b0, pc_immediate}, 32'd0);
        pc_model = pc_model + 32'd4;
      end
      if (imem_resp_valid) begin
        sb.push_back('{pc: pend_addr, dat: mem_word(pend_addr)});
        ncapt++;
        pend = 1'b0;
      end else if (pend) begin
        dly--;
      end
      if (imem_req_valid && imem_req_ready) begin
        pend      = 1'b1;
        pend_addr = imem_req_addr;
        dly       = $urandom_range(0, 3);
      end
    end
    chk("stream.sb_empty", sb.size(), 32'd0);
    chk("stream.fetch_count", fetch_count, nxfer);
    chk("stream.pc_advance", pc_model, START + 32'(4 * ncapt));
    chk("stream.progress", {31'b0, (nxfer >= 20)}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
